// File: rtl/fa_sched_pkg.sv
// Shared types and sizing helpers for the bit-serial full-adder scheduler.
package fa_sched_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // A single requester still needs a 1-bit ID field.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above rr_ptr_i, wrapping.
module rr_arbiter
  import fa_sched_pkg::*;
#(
  parameter int  NREQ = DEF_NREQ,
  localparam int ID_W = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] rr_ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [ID_W-1:0] winner_o
);

  logic [ID_W:0]   cand_sum;
  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    grant_o  = '0;
    winner_o = '0;
    found    = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_sum = {1'b0, rr_ptr_i} + (ID_W+1)'(k);
      if (cand_sum >= (ID_W+1)'(NREQ)) begin
        cand_sum = cand_sum - (ID_W+1)'(NREQ);
      end
      cand = cand_sum[ID_W-1:0];
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        winner_o      = cand;
      end
    end
  end

endmodule

// File: rtl/fa_serial_scheduler.sv
// Shares one external 1-bit full adder between NREQ requesters, one bit per clock, LSB first.
// Result is held on the response port until rsp_ready; no new request is taken meanwhile.
module fa_serial_scheduler
  import fa_sched_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  NREQ  = DEF_NREQ,
  localparam int ID_W  = id_w(NREQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_a,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_b,
  input  logic [NREQ-1:0]             req_cin,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_W-1:0]             rsp_id,
  output logic [WIDTH-1:0]            rsp_sum,
  output logic                        rsp_cout,
  output logic                        fa_a,
  output logic                        fa_b,
  output logic                        fa_cin,
  input  logic                        fa_sum,
  input  logic                        fa_cout
);

  localparam int IDX_W = $clog2(WIDTH);

  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic              carry_q;
  logic              rsp_valid_q;
  logic [IDX_W-1:0]  idx_q;
  logic [ID_W-1:0]   id_q, rr_ptr_q, rr_ptr_d, winner;
  logic [NREQ-1:0]   grant;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i    (req_valid),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (grant),
    .winner_o (winner)
  );

  assign rr_ptr_d = (winner == ID_W'(NREQ-1)) ? '0 : winner + 1'b1;

  // Grant is only offered while idle and out of reset, so at most one bit is ever high.
  assign req_ready = (state_q == IDLE && !reset) ? grant : '0;

  assign fa_a   = (state_q == RUN) & a_q[idx_q];
  assign fa_b   = (state_q == RUN) & b_q[idx_q];
  assign fa_cin = (state_q == RUN) & carry_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req_valid) begin
            a_q      <= req_a[winner];
            b_q      <= req_b[winner];
            carry_q  <= req_cin[winner];
            id_q     <= winner;
            idx_q    <= '0;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= RUN;
          end
        end
        RUN: begin
          sum_q[idx_q] <= fa_sum;
          carry_q      <= fa_cout;
          idx_q        <= idx_q + 1'b1;
          if (idx_q == IDX_W'(WIDTH-1)) begin
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fa_serial_scheduler.sv
// Bench for fa_serial_scheduler: per-cycle reference model plus directed scenarios with literal expectations.
module tb_fa_serial_scheduler;

  localparam int WIDTH = 8;
  localparam int NREQ  = 2;
  localparam int ID_W  = 1;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][WIDTH-1:0] req_a;
  logic [NREQ-1:0][WIDTH-1:0] req_b;
  logic [NREQ-1:0]            req_cin;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_W-1:0]            rsp_id;
  logic [WIDTH-1:0]           rsp_sum;
  logic                       rsp_cout;
  logic                       fa_a, fa_b, fa_cin, fa_sum, fa_cout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // External full-adder cell
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

  fa_serial_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .fa_a      (fa_a),
    .fa_b      (fa_b),
    .fa_cin    (fa_cin),
    .fa_sum    (fa_sum),
    .fa_cout   (fa_cout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int qget(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  // Reference model: mode 0 idle, 1 computing (m_cyc = bit in flight), 2 result presented.
  int m_mode = 0, m_cyc = 0, m_ptr = 0, m_id = 0, m_a = 0, m_b = 0, m_cin = 0;
  int dut_grants[$];
  int rsp_ids[$];
  int rsp_sums[$];

  always @(negedge clk) begin
    int c, exp_rdy, total_sum, mlow, cin_j;
    if (reset) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_id",    32'(rsp_id), 0);
      chk("rst_rsp_sum",   32'(rsp_sum), 0);
      chk("rst_rsp_cout",  32'(rsp_cout), 0);
      chk("rst_fa",        32'({fa_a, fa_b, fa_cin}), 0);
      m_mode = 0;
      m_ptr  = 0;
    end else begin
      c = -1;
      if (m_mode == 0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (c < 0 && req_valid[(m_ptr + k) % NREQ]) c = (m_ptr + k) % NREQ;
        end
      end
      exp_rdy = (c >= 0) ? (1 << c) : 0;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_mode == 2));
      if (m_mode == 1) begin
        mlow  = (1 << m_cyc) - 1;
        cin_j = ((m_a & mlow) + (m_b & mlow) + m_cin) >> m_cyc;
        chk("fa_a",   32'(fa_a),   32'((m_a >> m_cyc) & 1));
        chk("fa_b",   32'(fa_b),   32'((m_b >> m_cyc) & 1));
        chk("fa_cin", 32'(fa_cin), 32'(cin_j & 1));
      end else begin
        chk("fa_idle", 32'({fa_a, fa_b, fa_cin}), 0);
      end
      if (m_mode == 2) begin
        total_sum = m_a + m_b + m_cin;
        chk("rsp_sum",  32'(rsp_sum),  32'(total_sum & MASK));
        chk("rsp_cout", 32'(rsp_cout), 32'((total_sum >> WIDTH) & 1));
        chk("rsp_id",   32'(rsp_id),   32'(m_id));
      end
      for (int k = 0; k < NREQ; k++) begin
        if (req_valid[k] && req_ready[k]) dut_grants.push_back(k);
      end
      if (rsp_valid && rsp_ready) begin
        rsp_ids.push_back(int'(rsp_id));
        rsp_sums.push_back(int'({rsp_cout, rsp_sum}));
      end
      case (m_mode)
        0: if (c >= 0) begin
          m_a    = int'(req_a[c]);
          m_b    = int'(req_b[c]);
          m_cin  = int'(req_cin[c]);
          m_id   = c;
          m_ptr  = (c + 1) % NREQ;
          m_cyc  = 0;
          m_mode = 1;
        end
        1: begin
          m_cyc++;
          if (m_cyc == WIDTH) m_mode = 2;
        end
        default: if (rsp_ready) m_mode = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, output int lat, output logic [WIDTH-1:0] fa_bits,
                       output logic [WIDTH-1:0] sum, output logic cout, output int rid);
    int n;
    req_a[id] = a; req_b[id] = b; req_cin[id] = cin; req_valid[id] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[id] && n < 50) begin tick(); n++; end
    chk("grant_timeout", 32'(n >= 50), 0);
    tick();
    req_valid[id] = 1'b0;
    req_a[id] = ~a; req_b[id] = ~b; req_cin[id] = ~cin;
    lat = 0;
    fa_bits = '0;
    while (!rsp_valid && lat < 50) begin
      if (lat < WIDTH) fa_bits[lat] = fa_a;
      tick();
      lat++;
    end
    sum  = rsp_sum;
    cout = rsp_cout;
    rid  = int'(rsp_id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int lat, rid, n, seen;
    logic [WIDTH-1:0] fa_bits, sum;
    logic cout;
    int exp_g[4];
    int exp_s[4];

    reset = 1'b1; rsp_ready = 1'b1;
    req_valid = 2'b11; req_cin = '0;
    req_a[0] = 8'h01; req_b[0] = 8'h02; req_a[1] = 8'h03; req_b[1] = 8'h04;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_lit", 32'(req_ready), 0);
    reset = 1'b0;
    #1;
    chk("first_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    repeat (12) tick();

    // Single request from requester 0
    do_op(0, 8'h5A, 8'h33, 1'b0, lat, fa_bits, sum, cout, rid);
    chk("single_latency", 32'(lat), 32'(WIDTH));
    chk("single_fa_a_seq", 32'(fa_bits), 32'h5A);
    chk("single_sum", 32'(sum), 32'h8D);
    chk("single_cout", 32'(cout), 0);
    chk("single_id", 32'(rid), 0);
    repeat (3) tick();

    // Overflow from requester 1
    do_op(1, 8'hFF, 8'h01, 1'b1, lat, fa_bits, sum, cout, rid);
    chk("ovf_sum", 32'(sum), 32'h01);
    chk("ovf_cout", 32'(cout), 1);
    chk("ovf_id", 32'(rid), 1);
    repeat (3) tick();

    // Contention: both requesters continuously valid
    dut_grants.delete(); rsp_ids.delete(); rsp_sums.delete();
    req_a[0] = 8'h12; req_b[0] = 8'h34; req_cin[0] = 1'b0;
    req_a[1] = 8'h80; req_b[1] = 8'h80; req_cin[1] = 1'b1;
    req_valid = 2'b11;
    n = 0;
    while (rsp_ids.size() < 4 && n < 80) begin tick(); n++; end
    req_valid = 2'b00;
    chk("cont_timeout", 32'(n >= 80), 0);
    exp_g = '{0, 1, 0, 1};
    exp_s = '{32'h046, 32'h101, 32'h046, 32'h101};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("cont_grant%0d", k), 32'(qget(dut_grants, k)), 32'(exp_g[k]));
      chk($sformatf("cont_rsp_id%0d", k), 32'(qget(rsp_ids, k)), 32'(exp_g[k]));
      chk($sformatf("cont_sum%0d", k), 32'(qget(rsp_sums, k)), 32'(exp_s[k]));
    end
    repeat (3) tick();

    // Backpressure in DONE with both requesters still valid
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    n = 0;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    chk("bp_timeout", 32'(n >= 40), 0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_rsp_sum", 32'({rsp_cout, rsp_sum}), 32'h046);
      chk("bp_rsp_id", 32'(rsp_id), 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_next_accept", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    repeat (12) tick();

    // Reset in the middle of an operation
    req_a[0] = 8'h0F; req_b[0] = 8'h01; req_cin[0] = 1'b0; req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[0] && n < 50) begin tick(); n++; end
    tick();
    req_valid[0] = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (rsp_valid) seen++;
      tick();
    end
    chk("abort_no_rsp", 32'(seen), 0);
    do_op(0, 8'h10, 8'h20, 1'b0, lat, fa_bits, sum, cout, rid);
    chk("post_rst_sum", 32'(sum), 32'h30);
    chk("post_rst_cout", 32'(cout), 0);
    chk("post_rst_latency", 32'(lat), 32'(WIDTH));
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
